// File: rtl/pwm_capture.sv
// Servo PWM decoder: measures high time and rising-to-rising period in clk counts
// behind a synchronizer and glitch filter, publishing each full period with a strobe.
module pwm_capture #(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned TIMEOUT  = 1_048_575
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    output logic [19:0] duty_meas,
    output logic [19:0] period_meas,
    output logic        meas_valid,
    output logic        signal_lost
);

    localparam logic [19:0] TMO  = 20'(TIMEOUT);
    localparam logic [3:0]  FMAX = 4'(FILT_LEN - 1);

    typedef enum logic [1:0] {SYNC, HIGH, LOW} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic        filt_q, filt_d, filt_prev_q;
    logic [3:0]  fcnt_q, fcnt_d;
    logic [1:0]  prime_q, prime_d;
    logic        arm_q, arm_d;
    logic [19:0] hi_cnt_q, hi_cnt_d, per_cnt_q, per_cnt_d, hi_hold_q, hi_hold_d;
    logic [19:0] duty_q, duty_d, period_q, period_d;
    logic        valid_q, valid_d, lost_q, lost_d;
    logic        rise, fall, per_max;
    logic        load, capture_hi, publish, tmo;

    // A mismatch run must last FILT_LEN cycles before the filtered level follows it.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync_q[1] != filt_q) begin
            if (fcnt_q == FMAX) filt_d = sync_q[1];
            else                fcnt_d = fcnt_q + 4'd1;
        end
    end

    assign rise    = filt_q & ~filt_prev_q;
    assign fall    = ~filt_q & filt_prev_q;
    assign per_max = (per_cnt_q == TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SYNC;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (rise && arm_q) state_d = HIGH;
            HIGH:    if (fall) state_d = LOW;  else if (per_max) state_d = SYNC;
            LOW:     if (rise) state_d = HIGH; else if (per_max) state_d = SYNC;
            default: state_d = SYNC;
        endcase
    end

    // Edges win over a coinciding timeout.
    always_comb begin
        load       = 1'b0;
        capture_hi = 1'b0;
        publish    = 1'b0;
        tmo        = 1'b0;
        arm_d      = 1'b0;
        case (state_q)
            SYNC: begin
                load  = rise & arm_q;
                // Arm only once the line is known genuinely low, so a pulse already
                // in progress at reset release or after a timeout is never measured.
                arm_d = arm_q | fall | ((prime_q == 2'd2) & ~filt_q & ~sync_q[1]);
            end
            HIGH: begin
                capture_hi = fall;
                tmo        = ~fall & per_max;
            end
            LOW: begin
                load    = rise;
                publish = rise;
                tmo     = ~rise & per_max;
            end
            default: ;
        endcase
    end

    always_comb begin
        prime_d   = (prime_q == 2'd2) ? prime_q : prime_q + 2'd1;
        hi_hold_d = capture_hi ? hi_cnt_q : hi_hold_q;
        hi_cnt_d  = hi_cnt_q;
        per_cnt_d = per_cnt_q;
        if (load) begin
            hi_cnt_d  = 20'd1;
            per_cnt_d = 20'd1;
        end else begin
            if (state_q == HIGH && hi_cnt_q != TMO) hi_cnt_d = hi_cnt_q + 20'd1;
            if (!per_max) per_cnt_d = per_cnt_q + 20'd1;
        end
        valid_d  = publish;
        duty_d   = duty_q;
        period_d = period_q;
        lost_d   = lost_q;
        if (publish) begin
            duty_d   = hi_hold_q;
            period_d = per_cnt_q;
            lost_d   = 1'b0;
        end else if (tmo) begin
            duty_d   = '0;
            period_d = '0;
            lost_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            fcnt_q      <= '0;
            prime_q     <= '0;
            arm_q       <= 1'b0;
            hi_cnt_q    <= '0;
            per_cnt_q   <= '0;
            hi_hold_q   <= '0;
            duty_q      <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            lost_q      <= 1'b1;
        end else begin
            sync_q      <= {sync_q[0], pwm_in};
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
            prime_q     <= prime_d;
            arm_q       <= arm_d;
            hi_cnt_q    <= hi_cnt_d;
            per_cnt_q   <= per_cnt_d;
            hi_hold_q   <= hi_hold_d;
            duty_q      <= duty_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            lost_q      <= lost_d;
        end
    end

    assign duty_meas   = duty_q;
    assign period_meas = period_q;
    assign meas_valid  = valid_q;
    assign signal_lost = lost_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with scaled periods (4000-cycle frame, TIMEOUT=5000).
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwm_in;
    logic [19:0] duty_meas, period_meas;
    logic        meas_valid, signal_lost;

    pwm_capture #(.FILT_LEN(4), .TIMEOUT(5000)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
        .duty_meas(duty_meas), .period_meas(period_meas),
        .meas_valid(meas_valid), .signal_lost(signal_lost)
    );

    always #10 clk = ~clk;

    typedef struct {
        int hi; int lo; int ghi; int glo;
        int n; int ed; int ep; int el;
    } vec_t;

    typedef struct { int d; int p; } meas_t;

    int    pass_cnt = 0;
    int    total_cnt = 0;
    meas_t mq[$];
    logic  prev_v = 1'b0;
    vec_t  vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Every strobe is queued; it must be isolated and report duty < period.
    always @(negedge clk) begin
        if (rst_n && meas_valid) begin
            mq.push_back('{int'(duty_meas), int'(period_meas)});
            chk("strobe_shape", int'(!prev_v && duty_meas < period_meas), 1);
        end
        prev_v = rst_n & meas_valid;
    end

    // One cycle per iteration; optional 3-cycle glitch inside each phase.
    task automatic drive_pulse(input int hi, input int lo, input int ghi, input int glo);
        for (int c = 0; c < hi; c++) begin
            pwm_in = (ghi != 0 && c >= ghi && c < ghi + 3) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        for (int c = 0; c < lo; c++) begin
            pwm_in = (glo != 0 && c >= glo && c < glo + 3) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_meas(input string name, input int n, input int d, input int p, input int lost);
        chk({name, "_count"}, mq.size(), n);
        if (n > 0 && mq.size() > 0) begin
            chk({name, "_duty"}, mq[0].d, d);
            chk({name, "_period"}, mq[0].p, p);
        end
        chk({name, "_lost"}, int'(signal_lost), lost);
        mq.delete();
    endtask

    task automatic check_reset(input string name);
        chk({name, "_duty"}, int'(duty_meas), 0);
        chk({name, "_period"}, int'(period_meas), 0);
        chk({name, "_valid"}, int'(meas_valid), 0);
        chk({name, "_lost"}, int'(signal_lost), 1);
    endtask

    initial begin
        // hi, lo, glitch-in-high, glitch-in-low, published count/duty/period (of previous frame), lost
        vecs[0] = '{750, 3250, 0,    0,    0, 0,   0,    1};
        vecs[1] = '{750, 3250, 0,    0,    1, 750, 4000, 0};
        vecs[2] = '{750, 3250, 0,    0,    1, 750, 4000, 0};
        vecs[3] = '{500, 3500, 200,  1000, 1, 750, 4000, 0};
        vecs[4] = '{4,   100,  0,    0,    1, 500, 4000, 0};
        vecs[5] = '{600, 3400, 0,    0,    1, 4,   104,  0};
        vecs[6] = '{600, 3400, 0,    0,    1, 600, 4000, 0};

        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst_init");
        rst_n = 1'b1;
        repeat (50) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            drive_pulse(vecs[i].hi, vecs[i].lo, vecs[i].ghi, vecs[i].glo);
            check_meas($sformatf("vec%0d", i), vecs[i].n, vecs[i].ed, vecs[i].ep, vecs[i].el);
        end

        // Timeout with constant high, then recovery through rise-fall-rise.
        pwm_in = 1'b1;
        repeat (4990) @(negedge clk);
        check_meas("to_pre", 1, 600, 4000, 0);
        repeat (30) @(negedge clk);
        chk("to_duty", int'(duty_meas), 0);
        chk("to_period", int'(period_meas), 0);
        check_meas("to_post", 0, 0, 0, 1);
        pwm_in = 1'b0;
        repeat (1000) @(negedge clk);
        drive_pulse(700, 3300, 0, 0);
        check_meas("to_rec1", 0, 0, 0, 1);
        drive_pulse(700, 3300, 0, 0);
        check_meas("to_rec2", 1, 700, 4000, 0);

        // Startup with the line already high: the partial pulse must be skipped.
        rst_n  = 1'b0;
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        check_reset("rst_start");
        mq.delete();
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        pwm_in = 1'b0;
        repeat (3400) @(negedge clk);
        drive_pulse(600, 3400, 0, 0);
        check_meas("start1", 0, 0, 0, 1);
        drive_pulse(600, 3400, 0, 0);
        check_meas("start2", 1, 600, 4000, 0);

        // Reset in the middle of a high phase.
        pwm_in = 1'b1;
        repeat (200) @(negedge clk);
        mq.delete();
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid_a");
        repeat (10) @(negedge clk);
        check_reset("rst_mid_b");
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        pwm_in = 1'b0;
        repeat (3400) @(negedge clk);
        drive_pulse(600, 3400, 0, 0);
        check_meas("mid1", 0, 0, 0, 1);
        drive_pulse(600, 3400, 0, 0);
        check_meas("mid2", 1, 600, 4000, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
